// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the decode path.
//   imm_src_t  : 3-bit immediate format select (codes 6 and 7 are illegal)
//   imm_ext_t  : extension result (64-bit value plus illegal-select flag)
//   imm_extend : extracts and extends the immediate of a 32-bit instruction
//                to xlen bits (32 or 64); callers slice [XLEN-1:0]
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_src_t;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } imm_ext_t;

  function automatic imm_ext_t imm_extend(input logic [31:0] instr,
                                          input logic [2:0]  src,
                                          input int unsigned xlen);
    imm_ext_t r;
    logic     unused_opcode;
    r.imm = '0;
    r.err = 1'b0;
    // The opcode field never contributes to any immediate.
    unused_opcode = ^instr[6:0];
    case (src)
      IMM_I:   r.imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   r.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   r.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   r.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   r.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      IMM_Z:   r.imm = {59'b0, instr[19:15]};
      default: r.err = 1'b1;  // illegal select: value stays zero
    endcase
    if (xlen == 32) r.imm[63:32] = '0;
    return r;
  endfunction

endpackage

// File: rtl/imm_fifo.sv
// Generic synchronous FIFO with synchronous flush.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : discard all entries at the next edge
//   in_valid/in_ready     : write handshake, in_data written on push
//   out_valid/out_ready   : read handshake, out_data is the head entry
//   count                 : current occupancy (0..DEPTH)
// in_ready depends only on the registered count; a pop while full does
// not open a slot for a push in the same cycle. out_data reads 0 when empty.
module imm_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign in_ready  = (cnt != (AW+1)'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: empty entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: rtl/imm_gen_buf.sv
// Buffered immediate generator: extends the immediate of each accepted
// instruction and queues {imm, tag, err} for a possibly stalled consumer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : discard all queued entries
//   in_valid/in_ready   : instruction handshake (in_instr, in_imm_src, in_tag)
//   out_valid/out_ready : result handshake (out_imm, out_tag, out_err)
//   count               : FIFO occupancy
module imm_gen_buf
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [2:0]             in_imm_src,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_imm,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned W = XLEN + TAG_W + 1;

  imm_ext_t     ext;
  logic [W-1:0] fifo_in;
  logic [W-1:0] fifo_out;

  assign ext     = imm_extend(in_instr, in_imm_src, XLEN);
  assign fifo_in = {ext.imm[XLEN-1:0], in_tag, ext.err};

  if (XLEN < 64) begin : g_narrow
    logic unused_upper;
    assign unused_upper = ^ext.imm[63:XLEN];
  end

  imm_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (fifo_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .count     (count)
  );

  assign {out_imm, out_tag, out_err} = fifo_out;

endmodule

// File: tb/tb_imm_gen_buf.sv
module tb_imm_gen_buf;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [2:0]       count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_imm_src (in_imm_src),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .count      (count)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] instr, input logic [2:0] src, input logic [TAG_W-1:0] tag);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    in_tag     = tag;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic push_pop_check(input string name, input logic [31:0] instr, input logic [2:0] src,
                                input logic [TAG_W-1:0] tag, input logic [63:0] exp_imm,
                                input logic exp_err);
    push1(instr, src, tag);
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_imm"},   out_imm,            exp_imm);
    check({name, "_tag"},   {59'd0, out_tag},   {59'd0, tag});
    check({name, "_err"},   {63'd0, out_err},   {63'd0, exp_err});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_drained"}, {61'd0, count}, 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_imm_src = '0;
    in_tag     = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_tag", {59'd0, out_tag}, 64'd0);
    check("rst_err", {63'd0, out_err}, 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready", {63'd0, in_ready}, 64'd1);

    // Every format, one entry at a time
    push_pop_check("fmt_i",  32'hFFF00093, 3'd0, 5'd3,  64'hFFFFFFFFFFFFFFFF, 1'b0);
    push_pop_check("fmt_s",  32'h80000280, 3'd1, 5'd4,  64'hFFFFFFFFFFFFF805, 1'b0);
    push_pop_check("fmt_b",  32'hFE000EE3, 3'd2, 5'd5,  64'hFFFFFFFFFFFFFFFC, 1'b0);
    push_pop_check("fmt_u",  32'h800000B7, 3'd3, 5'd6,  64'hFFFFFFFF80000000, 1'b0);
    push_pop_check("fmt_j",  32'h2AB12000, 3'd4, 5'd7,  64'h0000000000012AAA, 1'b0);
    push_pop_check("fmt_z",  32'h000FD073, 3'd5, 5'd8,  64'h000000000000001F, 1'b0);
    push_pop_check("ill_7",  32'hFFFFFFFF, 3'd7, 5'd9,  64'h0, 1'b1);
    push_pop_check("ill_6",  32'hFFFFFFFF, 3'd6, 5'd10, 64'h0, 1'b1);

    // Fill to DEPTH with the consumer stalled; I-immediates 1..4, tags 11..14
    for (int i = 1; i <= 4; i++) begin
      push1(32'(i) << 20, 3'd0, 5'(10 + i));
      check("fill_count", {61'd0, count}, 64'(i));
    end
    check("full_ready", {63'd0, in_ready}, 64'd0);
    check("full_head_tag", {59'd0, out_tag}, 64'd11);
    check("held_imm", out_imm, 64'd1);
    step();
    check("held_after_stall", out_imm, 64'd1);

    // Full: pop and push requested together -> only the pop happens
    in_valid   = 1'b1;
    in_instr   = 32'd5 << 20;
    in_imm_src = 3'd0;
    in_tag     = 5'd15;
    out_ready  = 1'b1;
    step();
    out_ready  = 1'b0;
    check("fullpop_count", {61'd0, count}, 64'd3);
    check("fullpop_head", {59'd0, out_tag}, 64'd12);
    check("fullpop_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("late_push_count", {61'd0, count}, 64'd4);

    // Drain in order: tags 12..15, imm 2..5
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_tag", {59'd0, out_tag}, 64'(12 + i));
      check("drain_imm", out_imm, 64'(2 + i));
      step();
      check("drain_count", {61'd0, count}, 64'(3 - i));
    end
    out_ready = 1'b0;
    check("drain_empty_imm", out_imm, 64'd0);

    // Sustained throughput: push and pop every cycle with one entry in flight
    push1(32'd7 << 20, 3'd0, 5'd20);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'(8 + i) << 20;
      in_tag   = 5'(21 + i);
      step();
      check("stream_count", {61'd0, count}, 64'd1);
      check("stream_tag", {59'd0, out_tag}, 64'(21 + i));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_empty", {61'd0, count}, 64'd0);

    // Flush with three queued entries and a concurrent push
    for (int i = 0; i < 3; i++) push1(32'hFFF00093, 3'd0, 5'(i));
    check("preflush_count", {61'd0, count}, 64'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_tag   = 5'd30;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", {61'd0, count}, 64'd0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_imm", out_imm, 64'd0);
    step();
    check("flush_input_absent", {61'd0, count}, 64'd0);

    // Asynchronous reset mid-stream, applied away from any clock edge
    push1(32'hFFF00093, 3'd0, 5'd17);
    push1(32'hFFFFFFFF, 3'd7, 5'd18);
    check("prereset_count", {61'd0, count}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", {61'd0, count}, 64'd0);
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_imm", out_imm, 64'd0);
    check("arst_tag", {59'd0, out_tag}, 64'd0);
    check("arst_err", {63'd0, out_err}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_count", {61'd0, count}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
